// File: rtl/tdc_thermo_readout.sv
// tdc_thermo_readout
// Reader side of the tapped-delay-line TDC. On a sample request the
// thermometer code from the delay line is captured, single-bit bubbles are
// removed with a three-tap majority vote, the corrected code is reduced to a
// tap count, and one status+count byte is offered on a valid/ready port.
//
// out_data layout: {bubble, sat, count[5:0]}
//   bubble : the majority vote changed at least one captured bit
//   sat    : every tap was set, so the edge ran past the end of the line
//   count  : number of set taps after correction (0 is a legal result)
//
// Pipeline timing, relative to the accepting edge T:
//   T   : IDLE -> CAPT, therm captured
//   T+1 : CAPT -> FIX,  bubble correction registered
//   T+2 : FIX  -> CNT,  popcount registered
//   T+3 : CNT  -> HOLD, result byte and out_valid registered
//   HOLD waits for out_valid & out_ready, then returns to IDLE.
// rst_n is an active-high synchronous reset despite its name; it is kept for
// compatibility with the surrounding delay-line blocks.

module tdc_thermo_readout #(
  parameter int N_DELAY = 32,
  parameter int CW      = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample,
  input  logic [N_DELAY-1:0] therm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_data,
  output logic               busy,
  output logic               overrun
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CAPT = 3'd1,
    FIX  = 3'd2,
    CNT  = 3'd3,
    HOLD = 3'd4
  } state_t;

  state_t             state;

  // Pipeline registers: raw capture, corrected code, bubble flag, tap count.
  logic [N_DELAY-1:0] cap_reg;
  logic [N_DELAY-1:0] fix_reg;
  logic               bub_reg;
  logic [CW-1:0]      cnt_reg;

  // Combinational results feeding the pipeline registers.
  logic [N_DELAY+1:0] cap_ext;
  logic [N_DELAY-1:0] fix_next;
  logic [CW-1:0]      pop_count;
  logic               sat_flag;

  // The line is padded with a virtual 1 before tap 0 and a virtual 0 after
  // the last tap, so the end taps vote exactly like interior ones.
  assign cap_ext = {1'b0, cap_reg, 1'b1};

  // Three-tap majority vote removes isolated 0s inside the run of 1s and
  // isolated 1s beyond it.
  always_comb begin
    fix_next = '0;
    for (int i = 0; i < N_DELAY; i++) begin
      fix_next[i] = (cap_ext[i]   & cap_ext[i+1]) |
                    (cap_ext[i]   & cap_ext[i+2]) |
                    (cap_ext[i+1] & cap_ext[i+2]);
    end
  end

  // Tap count of the corrected code; after correction this is the edge position.
  always_comb begin
    pop_count = '0;
    for (int i = 0; i < N_DELAY; i++) begin
      pop_count = pop_count + CW'(fix_reg[i]);
    end
  end

  // Saturation: the corrected count covers the whole delay line.
  assign sat_flag = (cnt_reg == CW'(N_DELAY));

  // Measurement sequencer with registered status outputs and sticky overrun.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= IDLE;
      cap_reg   <= '0;
      fix_reg   <= '0;
      bub_reg   <= 1'b0;
      cnt_reg   <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (sample && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (sample) begin
            cap_reg <= therm;
            busy    <= 1'b1;
            state   <= CAPT;
          end
        end

        CAPT: begin
          fix_reg <= fix_next;
          bub_reg <= (fix_next != cap_reg);
          state   <= FIX;
        end

        FIX: begin
          cnt_reg <= pop_count;
          state   <= CNT;
        end

        CNT: begin
          out_data  <= {bub_reg, sat_flag, cnt_reg};
          out_valid <= 1'b1;
          state     <= HOLD;
        end

        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_thermo_readout.sv
// tb_tdc_thermo_readout
// Drives directed and randomized requests into tdc_thermo_readout and checks
// every cycle against a transaction-level model that tracks accept time,
// expected byte, handshake and the sticky overrun flag.

module tb_tdc_thermo_readout;

  localparam int N = 32;

  logic         clk;
  logic         rst_n;
  logic         sample;
  logic [N-1:0] therm;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic         busy;
  logic         overrun;

  int assert_cnt;
  int fail_cnt;
  bit checking;

  // Model state
  int         cyc;
  int         m_acc;
  bit         m_busy;
  bit         m_valid;
  bit         m_ovr;
  logic [7:0] m_data;
  logic [7:0] m_byte;

  tdc_thermo_readout #(.N_DELAY(N), .CW(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample    (sample),
    .therm     (therm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result byte from the textual rules: majority vote with a 1 before tap 0
  // and a 0 after the last tap, then count the ones.
  function automatic logic [7:0] modelDecode(input logic [N-1:0] t);
    logic [N+1:0] e;
    logic [N-1:0] f;
    int           votes;
    int           count;
    e = {1'b0, t, 1'b1};
    count = 0;
    for (int i = 0; i < N; i++) begin
      votes = int'(e[i]) + int'(e[i+1]) + int'(e[i+2]);
      f[i] = (votes >= 2);
      count += int'(f[i]);
    end
    return {(f != t), (count == N), 6'(count)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [N-1:0] t, input logic r, input logic rs);
    @(negedge clk);
    sample    = s;
    therm     = t;
    out_ready = r;
    rst_n     = rs;
  endtask

  // Transaction-level model, advanced on each rising edge from the inputs
  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      m_busy  = 1'b0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_data  = 8'h00;
    end else if (m_busy) begin
      if (sample) m_ovr = 1'b1;
      if (m_valid && out_ready) begin
        m_valid = 1'b0;
        m_busy  = 1'b0;
      end else if (cyc == m_acc + 3) begin
        m_valid = 1'b1;
        m_data  = m_byte;
      end
    end else if (sample) begin
      m_busy = 1'b1;
      m_acc  = cyc;
      m_byte = modelDecode(therm);
    end
  end

  // Per-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
      checkOutput("busy",      32'(busy),      32'(m_busy));
      checkOutput("overrun",   32'(overrun),   32'(m_ovr));
      checkOutput("out_data",  32'(out_data),  32'(m_data));
    end
  end

  // Accept one request, wait for the result, hold it for hold_cycles with
  // out_ready low, then handshake and confirm return to idle.
  task automatic runMeasurement(input logic [N-1:0] t, input logic [7:0] exp, input int hold_cycles);
    int  k;
    bit  seen;
    seen = 1'b0;
    applyStimulus(1'b1, t, 1'b0, 1'b0);
    for (k = 1; k <= 10; k++) begin
      applyStimulus(1'b0, ~t, 1'b0, 1'b0);
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checkOutput("valid_timeout", 32'd0, 32'd1);
    end else begin
      checkOutput("latency_edges", 32'(k - 1), 32'd3);
      checkOutput("result_byte", 32'(out_data), 32'(exp));
      for (int h = 0; h < hold_cycles; h++) begin
        applyStimulus(1'b0, $urandom, 1'b0, 1'b0);
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_data", 32'(out_data), 32'(exp));
      end
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("post_hs_valid", 32'(out_valid), 32'd0);
      checkOutput("post_hs_busy", 32'(busy), 32'd0);
      checkOutput("post_hs_data", 32'(out_data), 32'(exp));
    end
  endtask

  function automatic logic [N-1:0] genTherm();
    logic [63:0] one_run;
    int          k;
    case ($urandom_range(0, 4))
      0: begin
        k = $urandom_range(0, N);
        one_run = (64'd1 << k) - 64'd1;
        return one_run[N-1:0];
      end
      1: begin
        k = $urandom_range(0, N);
        one_run = (64'd1 << k) - 64'd1;
        one_run[$urandom_range(0, N-1)] ^= 1'b1;
        return one_run[N-1:0];
      end
      2: return '1;
      3: return '0;
      default: return N'($urandom);
    endcase
  endfunction

  // Watchdog so the run always terminates
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;
    assert_cnt = 0;
    fail_cnt   = 0;
    checking   = 1'b0;
    cyc        = 0;
    m_acc      = 0;
    m_busy     = 1'b0;
    m_valid    = 1'b0;
    m_ovr      = 1'b0;
    m_data     = 8'h00;
    m_byte     = 8'h00;
    sample     = 1'b0;
    therm      = '0;
    out_ready  = 1'b0;
    rst_n      = 1'b1;

    // Pin the model decoder to hand-computed bytes
    checkOutput("model_ff",   32'(modelDecode(32'h0000_00FF)), 32'h08);
    checkOutput("model_fb",   32'(modelDecode(32'h0000_00FB)), 32'h88);
    checkOutput("model_ones", 32'(modelDecode(32'hFFFF_FFFF)), 32'h60);
    checkOutput("model_zero", 32'(modelDecode(32'h0000_0000)), 32'h00);
    checkOutput("model_iso",  32'(modelDecode(32'h0000_0100)), 32'h80);

    // Reset state
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checking = 1'b1;
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    checkOutput("rst_data", 32'(out_data), 32'h00);

    $display("[TB] directed measurements");
    runMeasurement(32'h0000_00FF, 8'h08, 0);
    runMeasurement(32'h0000_00FB, 8'h88, 0);
    runMeasurement(32'hFFFF_FFFF, 8'h60, 0);
    runMeasurement(32'h0000_0000, 8'h00, 0);
    runMeasurement(32'h0000_0100, 8'h80, 5);

    $display("[TB] overrun during CAPT and HOLD");
    applyStimulus(1'b1, 32'h0000_00FF, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0000_0000, 1'b0, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("ovr_valid_seen", 32'(seen), 32'd1);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("ovr_data", 32'(out_data), 32'h08);
    checkOutput("ovr_sticky", 32'(overrun), 32'd1);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("ovr_single_result", 32'(out_valid), 32'd0);
    end
    checkOutput("ovr_still_set", 32'(overrun), 32'd1);

    $display("[TB] reset during FIX");
    applyStimulus(1'b1, 32'h0000_0FFF, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_overrun", 32'(overrun), 32'd0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("midrst_no_byte", 32'(out_valid), 32'd0);
    end
    runMeasurement(32'h0000_00FB, 8'h88, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(0, 2) == 0), genTherm(),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) == 0));
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checking = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
